// File: rtl/pwm_am_stream_modulator.sv
// AM PWM modulator: one buffered amplitude sample per PWM symbol, with
// left-aligned or centred pulses and a hold-or-zero policy on buffer underrun.
module pwm_am_stream_modulator #(
    parameter int CLKS_PER_STEP = 4,
    parameter int PWM_STEPS     = 64,
    parameter int SAMPLE_WIDTH  = 7,
    parameter int CENTERED      = 0,
    parameter int UNDERRUN_HOLD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    pwm,
    output logic                    symb_tick,
    output logic                    underrun
);

    // Compare width leaves headroom so start+duty never wraps at full duty.
    localparam int CW  = $clog2(PWM_STEPS + 1) + 1;
    localparam int SCW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam int PW  = $clog2(PWM_STEPS);
    localparam int LW  = (SAMPLE_WIDTH > CW) ? SAMPLE_WIDTH : CW;

    localparam logic [SCW-1:0] STEP_LAST = SCW'(CLKS_PER_STEP - 1);
    localparam logic [PW-1:0]  POS_LAST  = PW'(PWM_STEPS - 1);
    localparam logic [CW-1:0]  STEPS_C   = CW'(PWM_STEPS);
    localparam logic [LW-1:0]  STEPS_L   = LW'(PWM_STEPS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [SCW-1:0]          step_cnt;
    logic [PW-1:0]           pos;
    logic [CW-1:0]           duty;
    logic [SAMPLE_WIDTH-1:0] buf_data;
    logic                    buf_full;

    logic                    step_tick;
    logic                    sym_end;
    logic                    accept;
    logic                    hit;
    logic [LW-1:0]           buf_l;
    logic [CW-1:0]           buf_sat;
    logic [CW-1:0]           pos_c;
    logic [CW-1:0]           start;
    logic [CW-1:0]           stop;

    always_comb begin
        step_tick = enable && (step_cnt == STEP_LAST);
        sym_end   = step_tick && (pos == POS_LAST);
        accept    = sample_valid && !buf_full;
        buf_l     = LW'(buf_data);
        buf_sat   = (buf_l > STEPS_L) ? STEPS_C : CW'(buf_l);
        pos_c     = CW'(pos);
        // Left-aligned is the centred window with its start pinned to 0.
        start     = (CENTERED != 0) ? ((STEPS_C - duty) >> 1) : '0;
        stop      = start + duty;
        hit       = (pos_c >= start) && (pos_c < stop);
    end

    assign sample_ready = ~buf_full;
    assign symb_tick    = sym_end;
    assign underrun     = sym_end & ~buf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step_cnt <= '0;
            pos      <= '0;
            duty     <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            pwm <= enable & hit;

            case (state)
                IDLE:    if (enable)  state <= RUN;
                RUN:     if (!enable) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!enable) begin
                step_cnt <= '0;
                pos      <= '0;
            end else if (step_tick) begin
                step_cnt <= '0;
                pos      <= (pos == POS_LAST) ? '0 : pos + 1'b1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end

            // Duty only changes at a symbol boundary, so every symbol is whole.
            if (sym_end) begin
                if (buf_full) begin
                    duty     <= buf_sat;
                    buf_full <= 1'b0;
                end else if (UNDERRUN_HOLD == 0) begin
                    duty <= '0;
                end
            end

            if (accept) begin
                buf_data <= sample_data;
                buf_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_am_stream_modulator.sv
// Bench for pwm_am_stream_modulator: two instances (left-aligned/hold and
// centred/zero-on-underrun) share one stimulus stream against a symbol-level model.
module tb_pwm_am_stream_modulator;

    localparam int CPS   = 2;
    localparam int STEPS = 8;
    localparam int SW    = 4;
    localparam int SYM   = CPS * STEPS;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [SW-1:0] sample_data;
    logic          sample_valid;
    logic          ready_a, pwm_a, tick_a, under_a;
    logic          ready_b, pwm_b, tick_b, under_b;

    always #5 clk = ~clk;

    pwm_am_stream_modulator #(
        .CLKS_PER_STEP(CPS), .PWM_STEPS(STEPS), .SAMPLE_WIDTH(SW),
        .CENTERED(0), .UNDERRUN_HOLD(1)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(ready_a), .pwm(pwm_a), .symb_tick(tick_a), .underrun(under_a)
    );

    pwm_am_stream_modulator #(
        .CLKS_PER_STEP(CPS), .PWM_STEPS(STEPS), .SAMPLE_WIDTH(SW),
        .CENTERED(1), .UNDERRUN_HOLD(0)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(ready_b), .pwm(pwm_b), .symb_tick(tick_b), .underrun(under_b)
    );

    int n_vec  = 0;
    int n_fail = 0;

    logic [SYM-1:0] exp_a_q[$];
    logic [SYM-1:0] exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected pwm waveform over one symbol, first clock in the MSB.
    function automatic logic [SYM-1:0] pattern(input int d, input bit centered);
        logic [SYM-1:0] p;
        int st;
        p  = '0;
        st = centered ? (STEPS - d) / 2 : 0;
        for (int k = 0; k < SYM; k++) begin
            int s;
            s = k / CPS;
            p[SYM-1-k] = (s >= st) && (s < st + d);
        end
        return p;
    endfunction

    // Reference model: clock position inside the symbol, one-entry buffer, duty per instance.
    int m_cnt      = 0;
    int m_buf      = 0;
    int m_duty_a   = 0;
    int m_duty_b   = 0;
    bit m_full     = 1'b0;
    bit m_en_prev  = 1'b0;
    bit m_was_full = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0; m_buf = 0; m_duty_a = 0; m_duty_b = 0;
                m_full = 1'b0; m_en_prev = 1'b0;
                exp_a_q.delete();
                exp_b_q.delete();
            end else begin
                m_was_full = m_full;
                if (enable && m_cnt == SYM - 1) begin
                    exp_a_q.push_back(pattern(m_duty_a, 1'b0));
                    exp_b_q.push_back(pattern(m_duty_b, 1'b1));
                    if (m_was_full) begin
                        m_duty_a = (m_buf > STEPS) ? STEPS : m_buf;
                        m_duty_b = m_duty_a;
                        m_full   = 1'b0;
                    end else begin
                        m_duty_b = 0;
                    end
                end
                if (sample_valid && !m_was_full) begin
                    m_buf  = int'(sample_data);
                    m_full = 1'b1;
                end
                m_cnt     = enable ? (m_cnt + 1) % SYM : 0;
                m_en_prev = enable;
            end
        end
    end

    // Monitor: per-cycle flags, plus a whole-symbol waveform compare after each symb_tick.
    logic [SYM-1:0] win_a, win_b, ea, eb;
    bit             tick_d, exp_tick;

    initial begin
        tick_d = 1'b0;
        win_a  = '0;
        win_b  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_outputs_a", 32'({pwm_a, tick_a, under_a, ready_a}), 32'h1);
                check("rst_outputs_b", 32'({pwm_b, tick_b, under_b, ready_b}), 32'h1);
                tick_d = 1'b0;
            end else begin
                exp_tick = enable && (m_cnt == SYM - 1);
                check("ready_a", 32'(ready_a), 32'(!m_full));
                check("ready_b", 32'(ready_b), 32'(!m_full));
                check("symb_tick_a", 32'(tick_a), 32'(exp_tick));
                check("symb_tick_b", 32'(tick_b), 32'(exp_tick));
                check("underrun_a", 32'(under_a), 32'(exp_tick && !m_full));
                check("underrun_b", 32'(under_b), 32'(exp_tick && !m_full));
                if (!m_en_prev) begin
                    check("idle_pwm_a", 32'(pwm_a), 32'h0);
                    check("idle_pwm_b", 32'(pwm_b), 32'h0);
                end
                win_a = {win_a[SYM-2:0], pwm_a};
                win_b = {win_b[SYM-2:0], pwm_b};
                if (tick_d) begin
                    if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_symbol: got symbol end, expected none (t=%0t)", $time);
                    end else begin
                        ea = exp_a_q.pop_front();
                        eb = exp_b_q.pop_front();
                        check("symbol_pwm_a", 32'(win_a), 32'(ea));
                        check("symbol_pwm_b", 32'(win_b), 32'(eb));
                    end
                end
                tick_d = tick_a;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a sample and hold valid until the handshake completes (bounded).
    task automatic send(input int d);
        bit acc;
        acc          = 1'b0;
        sample_data  = SW'(d);
        sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            acc = ready_a;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        sample_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got no handshake for %0d, expected accept within 300 clocks", d);
        end
    endtask

    int n;
    int off_cnt;

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        step(3);
        rst    = 1'b0;
        enable = 1'b1;

        // First symbol end lands on the 16th clock after release.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 100);
        check("first_tick_clock", 32'(n), 32'(SYM));
        @(posedge clk);
        #1;

        send(3); send(5); step(40);
        send(12); step(34);
        send(0); step(34);
        send(4); send(3); step(40);
        send(5); step(SYM * 4);

        // Enable dropped mid-symbol; a sample is taken while idle.
        step(5);
        enable = 1'b0;
        step(3);
        send(6);
        step(5);
        enable = 1'b1;
        step(40);

        // Reset mid-run with a held sample pending.
        send(7); step(20);
        send(2); step(3);
        rst = 1'b1;
        #1;
        check("async_rst_a", 32'({pwm_a, tick_a, under_a, ready_a}), 32'h1);
        check("async_rst_b", 32'({pwm_b, tick_b, under_b, ready_b}), 32'h1);
        step(2);
        rst = 1'b0;
        step(40);

        off_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (off_cnt > 0) begin
                off_cnt--;
                enable = (off_cnt == 0);
            end else if ($urandom_range(0, 249) == 0) begin
                enable  = 1'b0;
                off_cnt = $urandom_range(1, 20);
            end
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_data  = SW'($urandom_range(0, 15));
            step(1);
        end

        enable       = 1'b1;
        sample_valid = 1'b0;
        step(SYM * 2 + 4);
        @(negedge clk);
        #1;
        check("drain_queue_a", 32'(exp_a_q.size()), 32'h0);
        check("drain_queue_b", 32'(exp_b_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
